// File: rtl/seq_divider.sv
// Sequential signed divider for the UART calculator datapath.
// It uses restoring division on the operand magnitudes and produces one quotient bit
// per clock, then sets the signs so that the quotient truncates toward zero.
// The result is returned as calc_res = {remainder, quotient}.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               parser_done,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  output logic [2*WIDTH-1:0] calc_res,
  output logic               div_done,
  output logic               dz_err,
  output logic               ovf_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  // Start detection: a two-flop edge detector, followed by one register stage on the pulse.
  logic             r_d1;
  logic             r_d2;
  logic             r_start;

  logic [CW-1:0]    r_cnt;

  // Division state. Magnitudes are held unsigned in WIDTH bits, so |MIN| (2^(WIDTH-1)) fits exactly.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_dvd_neg;
  logic             r_quo_neg;
  logic             r_dz;
  logic             r_ovf;

  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_shift;
  logic             w_trial_ok;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_start;

  assign w_start = r_start;

  // Operand magnitudes. Two's-complement negation of MIN wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_abs1 = src1[WIDTH-1] ? (~src1 + 1'b1) : src1;
  assign w_abs2 = src2[WIDTH-1] ? (~src2 + 1'b1) : src2;

  // One restoring step. The trial subtraction succeeds when the shifted remainder is at least the divisor.
  // The low WIDTH bits of the modular difference are exact whenever the trial succeeds.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial_ok = (w_shift >= {1'b0, r_dvs});
  assign w_trial    = w_shift[WIDTH-1:0] - r_dvs;

  // Sign fix-up: the quotient is negated when the operand signs differ, and the remainder follows the dividend's sign.
  // Dividing by zero forces the quotient to all ones.
  assign w_quo_fix = r_dz      ? '1 :
                     r_quo_neg ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_dvd_neg ? (~r_rem + 1'b1) : r_rem;

  // Edge detector on parser_done. A rise is registered once, so a held-high level gives exactly one start.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_d1    <= 1'b0;
      r_d2    <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_d1    <= parser_done;
      r_d2    <= r_d1;
      r_start <= r_d1 & ~r_d2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic. A start seen outside IDLE is dropped.
  // NOTE: next state defaults to the current state before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next_state = S_CALC;
      S_CALC: if (r_cnt == LAST_CNT) w_next_state = S_FIX;
      S_FIX:  w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // div_done is a decode of the registered state, so it is high only for the single DONE cycle.
  assign div_done = (r_state == S_DONE);

  // Datapath: latch operands on entry to CALC, shift and subtract once per CALC cycle, publish results in FIX.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_dvd_neg <= 1'b0;
      r_quo_neg <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
      calc_res  <= '0;
      dz_err    <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_dvs     <= w_abs2;
            r_dvd_neg <= src1[WIDTH-1];
            r_quo_neg <= src1[WIDTH-1] ^ src2[WIDTH-1];
            r_dz      <= (src2 == '0);
            r_ovf     <= (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src2 == '1);
          end
        end
        S_CALC: begin
          r_rem <= w_trial_ok ? w_trial : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
          r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end
        S_FIX: begin
          calc_res <= {w_rem_fix, w_quo_fix};
          dz_err   <= r_dz;
          ovf_err  <= r_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider. It checks a table of signed divisions, measures latency,
// and covers the held-start, dropped-edge and reset-abort sequences.
module tb_seq_divider;

  logic        clk;
  logic        n_rst;
  logic        parser_done;
  logic [15:0] src1;
  logic [15:0] src2;
  logic [31:0] calc_res;
  logic        div_done;
  logic        dz_err;
  logic        ovf_err;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int EXP_LAT = 19;

  seq_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .parser_done (parser_done),
    .src1        (src1),
    .src2        (src2),
    .calc_res    (calc_res),
    .div_done    (div_done),
    .dz_err      (dz_err),
    .ovf_err     (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        dz;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse parser_done for three cycles and wait for div_done.
  // k counts edges from E0 (the first edge that samples parser_done=1).
  task automatic run_div(input vec_t v, input string name);
    int lat;
    lat = -1;
    @(negedge clk);
    src1 = v.a;
    src2 = v.b;
    parser_done = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 2) parser_done = 1'b0;
      if (div_done) begin
        lat = k;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(EXP_LAT));
    check({name, " calc_res"}, calc_res, v.res);
    check({name, " dz_err"}, {31'd0, dz_err}, {31'd0, v.dz});
    check({name, " ovf_err"}, {31'd0, ovf_err}, {31'd0, v.ovf});
    @(posedge clk); #1;
    check({name, " done one cycle"}, {31'd0, div_done}, 32'd0);
    check({name, " result held"}, calc_res, v.res);
    repeat (2) @(posedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    int pulses;
    int lat;
    logic [31:0] got;

    vecs[0] = '{16'd100,  16'd7,      32'h0002_000E, 1'b0, 1'b0};
    vecs[1] = '{-16'sd100, 16'd7,     32'hFFFE_FFF2, 1'b0, 1'b0};
    vecs[2] = '{16'd100,  -16'sd7,    32'h0002_FFF2, 1'b0, 1'b0};
    vecs[3] = '{-16'sd100, -16'sd7,   32'hFFFE_000E, 1'b0, 1'b0};
    vecs[4] = '{16'd7,    16'd0,      32'h0007_FFFF, 1'b1, 1'b0};
    vecs[5] = '{16'd9,    16'd3,      32'h0000_0003, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF,   32'h0000_8000, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'd1,      32'h0000_8000, 1'b0, 1'b0};
    vecs[8] = '{16'd5,    16'd9,      32'h0005_0000, 1'b0, 1'b0};
    vecs[9] = '{-16'sd7,  16'd0,      32'hFFF9_FFFF, 1'b1, 1'b0};

    n_rst = 1'b0;
    parser_done = 1'b0;
    src1 = '0;
    src2 = '0;
    #1;
    check("reset calc_res", calc_res, 32'd0);
    check("reset div_done", {31'd0, div_done}, 32'd0);
    check("reset dz_err", {31'd0, dz_err}, 32'd0);
    check("reset ovf_err", {31'd0, ovf_err}, 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_div(vecs[i], $sformatf("vec%0d", i));

    // parser_done held high for 50 cycles while the operands change mid-CALC: expect exactly one result, 1000/3.
    @(negedge clk);
    src1 = 16'd1000;
    src2 = 16'd3;
    parser_done = 1'b1;
    pulses = 0;
    lat = -1;
    got = '0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        src1 = 16'd50;
        src2 = 16'd5;
      end
      if (k == 49) parser_done = 1'b0;
      if (div_done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          got = calc_res;
        end
      end
    end
    check("held pulses", 32'(pulses), 32'd1);
    check("held latency", 32'(lat), 32'(EXP_LAT));
    check("held calc_res", got, 32'h0001_014D);

    // A second rising edge arrives during CALC and must be dropped.
    @(negedge clk);
    src1 = 16'd100;
    src2 = 16'd7;
    parser_done = 1'b1;
    pulses = 0;
    lat = -1;
    got = '0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (k == 2) parser_done = 1'b0;
      if (k == 6) parser_done = 1'b1;
      if (k == 8) parser_done = 1'b0;
      if (div_done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          got = calc_res;
        end
      end
    end
    check("reedge pulses", 32'(pulses), 32'd1);
    check("reedge latency", 32'(lat), 32'(EXP_LAT));
    check("reedge calc_res", got, 32'h0002_000E);

    // Leave dz_err set and calc_res nonzero, then reset in the middle of CALC (cnt=8).
    run_div(vecs[4], "pre-abort");
    @(negedge clk);
    src1 = 16'd100;
    src2 = 16'd7;
    parser_done = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) parser_done = 1'b0;
    end
    n_rst = 1'b0;
    #1;
    check("abort calc_res", calc_res, 32'd0);
    check("abort div_done", {31'd0, div_done}, 32'd0);
    check("abort dz_err", {31'd0, dz_err}, 32'd0);
    check("abort ovf_err", {31'd0, ovf_err}, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (div_done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    run_div(vecs[0], "after-abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
